// File: rtl/car_sensor_pkg.sv
// Shared types and constants for the side-road car sensor conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package car_sensor_pkg;

  // FSM encoding is fixed so the state register can be read directly in debug.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    PENDING = 2'd2,
    SERVING = 2'd3
  } state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned DEB_CNT_W           = 8;
  localparam int unsigned EVENT_CNT_W         = 16;

  typedef logic [DEB_CNT_W-1:0]   deb_cnt_t;
  typedef logic [EVENT_CNT_W-1:0] event_cnt_t;

  // Saturating increments: neither counter is ever allowed to wrap.
  function automatic deb_cnt_t deb_sat_inc(input deb_cnt_t v);
    return (v == '1) ? v : v + deb_cnt_t'(1);
  endfunction

  function automatic event_cnt_t event_sat_inc(input event_cnt_t v);
    return (v == '1) ? v : v + event_cnt_t'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level into the clk domain.
// Latency: 2 clk edges from d to q.
// Backpressure: none; level signal, sampled every cycle.
//
// Ports: clk, rst (async active-high, clears both flops), d (async level in),
//        q (synchronized level out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/car_sensor_conditioner.sv
// Debounces a side-road loop detector and latches a service request until green.
// Latency: raw high held from edge N -> side_car_detected high after edge N+1+DEBOUNCE_CYCLES.
// Backpressure: none; request is held until side_green acknowledges it.
//
// Ports: clk, rst (async active-high), sensor_raw (async, bouncy loop level),
//        side_green (lamp feedback), side_car_detected (registered request),
//        event_count (16-bit saturating count of qualified requests, only when
//        CAR_EVENT_COUNT_EN is defined).
// Optional feature macro: CAR_EVENT_COUNT_EN.
module car_sensor_conditioner
  import car_sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_raw,
  input  logic side_green,
  output logic side_car_detected
`ifdef CAR_EVENT_COUNT_EN
  ,
  output logic [EVENT_CNT_W-1:0] event_count
`endif
);

  // Count value at which the current synchronized-high sample completes qualification.
  localparam deb_cnt_t DEB_LAST = deb_cnt_t'(DEBOUNCE_CYCLES - 1);

  logic     s_sync;
  state_t   state_q, state_d;
  deb_cnt_t deb_cnt_q, deb_cnt_d;
  logic     det_q, det_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sensor_raw),
    .q   (s_sync)
  );

  always_comb begin
    state_d   = state_q;
    deb_cnt_d = '0;           // count only lives in QUALIFY
    case (state_q)
      IDLE: begin
        if (s_sync) begin
          state_d   = QUALIFY;
          deb_cnt_d = deb_cnt_t'(1);
        end
      end
      QUALIFY: begin
        if (!s_sync) begin
          state_d = IDLE;     // any low sample restarts qualification
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d = PENDING;
        end else begin
          deb_cnt_d = deb_sat_inc(deb_cnt_q);
        end
      end
      PENDING: begin
        // Request is latched: sensor dropping out does not withdraw it.
        if (side_green) state_d = SERVING;
      end
      SERVING: begin
        if (!side_green) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Output flop tracks the PENDING state exactly, one register per bit.
    det_d = (state_d == PENDING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      deb_cnt_q <= '0;
      det_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      det_q     <= det_d;
    end
  end

  assign side_car_detected = det_q;

`ifdef CAR_EVENT_COUNT_EN
  logic       qualified;
  event_cnt_t event_cnt_q, event_cnt_d;

  assign qualified = (state_q == QUALIFY) && (state_d == PENDING);

  always_comb begin
    event_cnt_d = qualified ? event_sat_inc(event_cnt_q) : event_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) event_cnt_q <= '0;
    else     event_cnt_q <= event_cnt_d;
  end

  assign event_count = event_cnt_q;
`endif

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// Directed bench for car_sensor_conditioner with a queue-based scoreboard.
// Latency: expectations are pushed per clock edge and checked 2 time units later.
// Backpressure: n/a.
module tb_car_sensor_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sensor_raw = 1'b0;
  logic side_green = 1'b0;
  logic side_car_detected;
`ifdef CAR_EVENT_COUNT_EN
  logic [15:0] event_count;
`endif

  car_sensor_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .sensor_raw        (sensor_raw),
    .side_green        (side_green),
    .side_car_detected (side_car_detected)
`ifdef CAR_EVENT_COUNT_EN
    ,
    .event_count       (event_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        det;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        async_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  string       phase = "reset";
  logic [15:0] exp_cnt = 16'd0;
  event        async_chk;

  task automatic check(input exp_t e);
    n_cmp++;
    if (side_car_detected !== e.det) begin
      n_bad++;
      $display("FAIL %s: side_car_detected got %0b want %0b at %0t", e.tag, side_car_detected, e.det, $time);
    end
`ifdef CAR_EVENT_COUNT_EN
    n_cmp++;
    if (event_count !== e.cnt) begin
      n_bad++;
      $display("FAIL %s: event_count got %0h want %0h at %0t", e.tag, event_count, e.cnt, $time);
    end
`endif
  endtask

  // Monitor: one expectation per clock edge, sampled away from the edge.
  always @(posedge clk) begin
    #2;
    if (sb_q.size() > 0) check(sb_q.pop_front());
  end

  // Monitor for checks made between edges (asynchronous reset).
  always @(async_chk) begin
    if (async_q.size() > 0) check(async_q.pop_front());
  end

  // Drive inputs, take one edge, and record what the outputs must be after it.
  task automatic step(input logic r, input logic g, input logic d);
    sensor_raw = r;
    side_green = g;
    @(posedge clk);
    sb_q.push_back('{det: d, cnt: exp_cnt, tag: phase});
    #1;
  endtask

  task automatic steps(input int n, input logic r, input logic g, input logic d);
    for (int i = 0; i < n; i++) step(r, g, d);
  endtask

  // Reset pulse strictly between edges; output must drop without a clock.
  task automatic rst_pulse();
    #2 rst = 1'b1;
    #1;
    exp_cnt = 16'd0;
    async_q.push_back('{det: 1'b0, cnt: 16'd0, tag: {phase, "_async"}});
    -> async_chk;
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    phase = "reset";
    steps(2, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    phase = "idle";
    steps(3, 1'b0, 1'b0, 1'b0);

    // Sensor held high: five edges low, high after the sixth.
    phase = "latency";
    steps(5, 1'b1, 1'b0, 1'b0);
    exp_cnt = 16'd1;
    steps(3, 1'b1, 1'b0, 1'b1);

    // Sensor drops: request stays latched.
    phase = "pending_hold";
    steps(5, 1'b0, 1'b0, 1'b1);

    // Green serves the request, then back to idle.
    phase = "green";
    steps(3, 1'b0, 1'b1, 1'b0);
    steps(3, 1'b0, 1'b0, 1'b0);

    // Bounce 3 high / 1 low / 3 high never qualifies.
    phase = "bounce";
    steps(3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    steps(3, 1'b1, 1'b0, 1'b0);
    steps(4, 1'b0, 1'b0, 1'b0);

    // Green during IDLE/QUALIFY is ignored; request then served immediately.
    phase = "green_ignored";
    steps(5, 1'b1, 1'b1, 1'b0);
    exp_cnt = 16'd2;
    step(1'b1, 1'b1, 1'b1);
    steps(2, 1'b1, 1'b1, 1'b0);

    // Car still present after green must re-qualify from IDLE.
    phase = "requalify";
    steps(4, 1'b1, 1'b0, 1'b0);
    exp_cnt = 16'd3;
    step(1'b1, 1'b0, 1'b1);

    // Green and synchronized sensor fall on the same edge -> SERVING.
    phase = "green_and_drop";
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    steps(3, 1'b0, 1'b0, 1'b0);

    // Reset while PENDING drops the request; re-qualify takes 6 edges.
    phase = "rst_pending";
    steps(5, 1'b1, 1'b0, 1'b0);
    exp_cnt = 16'd4;
    step(1'b1, 1'b0, 1'b1);
    rst_pulse();
    steps(5, 1'b1, 1'b0, 1'b0);
    exp_cnt = 16'd1;
    step(1'b1, 1'b0, 1'b1);

    // Reset mid-QUALIFY also restarts from scratch.
    phase = "rst_qualify";
    step(1'b0, 1'b1, 1'b0);
    steps(3, 1'b0, 1'b0, 1'b0);
    steps(3, 1'b1, 1'b0, 1'b0);
    rst_pulse();
    steps(5, 1'b1, 1'b0, 1'b0);
    exp_cnt = 16'd1;
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    steps(3, 1'b0, 1'b0, 1'b0);

`ifdef CAR_EVENT_COUNT_EN
    // Counter saturation: preload near the top, qualify twice.
    phase = "saturate";
    #2;
    dut.event_cnt_q = 16'hFFFE;
    exp_cnt = 16'hFFFE;
    step(1'b0, 1'b0, 1'b0);
    steps(5, 1'b1, 1'b0, 1'b0);
    exp_cnt = 16'hFFFF;
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    steps(3, 1'b0, 1'b0, 1'b0);
    steps(5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
`endif

    // Every expectation must have been consumed by the monitors.
    @(posedge clk);
    #3;
    n_cmp++;
    if (sb_q.size() != 0 || async_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size() + async_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
